sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single SDRAM controller port.
// Grants alternate between the masters on every accepted command, and a small
// tag FIFO records which master issued each outstanding read so that returning
// read data can be steered back to the right master with zero latency.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // master 0
  input  logic [ADDR_W-1:0]         m0_address,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_W-1:0]         m0_writedata,
  input  logic [DATA_W/8-1:0]       m0_byteenable,
  output logic                      m0_waitrequest,
  output logic [DATA_W-1:0]         m0_readdata,
  output logic                      m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]         m1_address,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_W-1:0]         m1_writedata,
  input  logic [DATA_W/8-1:0]       m1_byteenable,
  output logic                      m1_waitrequest,
  output logic [DATA_W-1:0]         m1_readdata,
  output logic                      m1_readdatavalid,
  // SDRAM controller slave
  output logic [ADDR_W-1:0]         s_address,
  output logic                      s_read,
  output logic                      s_write,
  output logic [DATA_W-1:0]         s_writedata,
  output logic [DATA_W/8-1:0]       s_byteenable,
  input  logic                      s_waitrequest,
  input  logic [DATA_W-1:0]         s_readdata,
  input  logic                      s_readdatavalid,
  // status
  output logic [$clog2(TAG_DEPTH):0] rd_pending,
  output logic                      err_unexp_rdv
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;     // 0: master 0 wins an IDLE tie
  logic               tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  logic               m0_req, m1_req;
  logic               own_id;             // which master the OWN state refers to
  logic               own_read, own_write, oth_req;
  state_e             oth_state;
  logic               tag_full, tag_empty;
  logic               accept, push, pop, head_id;

  assign m0_req    = m0_read | m0_write;
  assign m1_req    = m1_read | m1_write;
  assign own_id    = (state_q == ST_OWN1);
  assign own_read  = own_id ? m1_read  : m0_read;
  assign own_write = own_id ? m1_write : m0_write;
  assign oth_req   = own_id ? m0_req   : m1_req;
  assign oth_state = own_id ? ST_OWN0  : ST_OWN1;
  assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);

  // Grant selection, slave command mux and next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d        = state_q;
    prio_d         = prio_q;
    s_address      = '0;
    s_writedata    = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    accept         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && (!prio_q || !m1_req)) state_d = ST_OWN0;
        else if (m1_req)                    state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        s_address    = own_id ? m1_address    : m0_address;
        s_writedata  = own_id ? m1_writedata  : m0_writedata;
        s_byteenable = own_id ? m1_byteenable : m0_byteenable;
        // A full tag FIFO stalls reads only; a simultaneous read+write is a
        // read and the write half is dropped.
        s_read       = own_read & ~tag_full;
        s_write      = own_write & ~own_read;
        accept       = (s_read | s_write) & ~s_waitrequest;
        if (own_id) m1_waitrequest = ~accept;
        else        m0_waitrequest = ~accept;
        if (accept) begin
          prio_d  = ~own_id;
          state_d = oth_req ? oth_state : state_q;
        end else if (!own_read && !own_write) begin
          state_d = oth_req ? oth_state : ST_IDLE;
        end
        // Otherwise the owner is stalled and keeps the grant.
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  assign push    = accept & s_read;
  assign pop     = s_readdatavalid & ~tag_empty;
  assign head_id = tag_mem[rd_ptr_q];

  // Tag storage: master ID of each accepted read, in issue order.
  always_ff @(posedge clk) begin
    // NOTE: the tag array has no reset; entries are only read while the count
    // says they are valid, so clearing them would be wasted logic.
    if (push) tag_mem[wr_ptr_q] <= own_id;
  end

  // Tag FIFO pointers and occupancy; push and pop together leave count as is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for read data that arrives with nothing outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          err_q <= 1'b0;
    else if (s_readdatavalid && tag_empty) err_q <= 1'b1;
  end

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head_id;
  assign m1_readdatavalid = pop & head_id;
  assign rd_pending       = count_q;
  assign err_unexp_rdv    = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a
// randomized run, all scored against a transaction-level reference model
// (owner index, priority, queue of outstanding read owners, sticky error).
module tb_sdram_port_arbiter;

  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 16;
  localparam int TAG_DEPTH = 4;
  localparam int BE_W      = DATA_W / 8;
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [CNT_W-1:0]  rd_pending;
  logic              err_unexp_rdv;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .rd_pending(rd_pending), .err_unexp_rdv(err_unexp_rdv)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: -1 = nobody owns the slave port.
  int own_m;
  int prio_m;
  int tagq[$];
  bit err_m;
  int last_acc;

  task automatic model_reset();
    own_m  = -1;
    prio_m = 0;
    tagq.delete();
    err_m  = 1'b0;
    last_acc = -1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0;
    m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '1; m1_byteenable = '1;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
  endtask

  // One clock: score every DUT output against the model, advance the model,
  // then step to the next falling edge where stimulus may change.
  task automatic tick();
    bit rq[2], wq[2], req[2];
    logic [ADDR_W-1:0] ad[2];
    logic [DATA_W-1:0] wd[2];
    logic [BE_W-1:0]   be[2];
    bit e_sr, e_sw, acc;
    bit e_wait[2], e_rdv[2];
    int oth;
    #1;
    rq[0] = m0_read;  rq[1] = m1_read;
    wq[0] = m0_write; wq[1] = m1_write;
    req[0] = rq[0] | wq[0]; req[1] = rq[1] | wq[1];
    ad[0] = m0_address; ad[1] = m1_address;
    wd[0] = m0_writedata; wd[1] = m1_writedata;
    be[0] = m0_byteenable; be[1] = m1_byteenable;
    e_sr = 0; e_sw = 0; acc = 0;
    e_wait[0] = 1; e_wait[1] = 1; e_rdv[0] = 0; e_rdv[1] = 0;
    if (own_m >= 0) begin
      e_sr = rq[own_m] && (tagq.size() < TAG_DEPTH);
      e_sw = wq[own_m] && !rq[own_m];
      acc  = (e_sr || e_sw) && !s_waitrequest;
      e_wait[own_m] = !acc;
    end
    if (s_readdatavalid && tagq.size() > 0) e_rdv[tagq[0]] = 1;

    checks++; if (s_read !== e_sr) begin errors++;
      $display("FAIL c%0d s_read: got %b exp %b", cyc, s_read, e_sr); end
    checks++; if (s_write !== e_sw) begin errors++;
      $display("FAIL c%0d s_write: got %b exp %b", cyc, s_write, e_sw); end
    checks++; if (m0_waitrequest !== e_wait[0]) begin errors++;
      $display("FAIL c%0d m0_waitrequest: got %b exp %b", cyc, m0_waitrequest, e_wait[0]); end
    checks++; if (m1_waitrequest !== e_wait[1]) begin errors++;
      $display("FAIL c%0d m1_waitrequest: got %b exp %b", cyc, m1_waitrequest, e_wait[1]); end
    checks++; if (m0_readdatavalid !== e_rdv[0]) begin errors++;
      $display("FAIL c%0d m0_readdatavalid: got %b exp %b", cyc, m0_readdatavalid, e_rdv[0]); end
    checks++; if (m1_readdatavalid !== e_rdv[1]) begin errors++;
      $display("FAIL c%0d m1_readdatavalid: got %b exp %b", cyc, m1_readdatavalid, e_rdv[1]); end
    checks++; if (rd_pending !== CNT_W'(tagq.size())) begin errors++;
      $display("FAIL c%0d rd_pending: got %0d exp %0d", cyc, rd_pending, tagq.size()); end
    checks++; if (err_unexp_rdv !== err_m) begin errors++;
      $display("FAIL c%0d err_unexp_rdv: got %b exp %b", cyc, err_unexp_rdv, err_m); end
    checks++; if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin errors++;
      $display("FAIL c%0d readdata: got %h/%h exp %h", cyc, m0_readdata, m1_readdata, s_readdata); end
    if (own_m >= 0) begin
      checks++;
      if (s_address !== ad[own_m] || s_writedata !== wd[own_m] || s_byteenable !== be[own_m]) begin
        errors++;
        $display("FAIL c%0d slave fields: got %h/%h/%b exp %h/%h/%b", cyc, s_address,
                 s_writedata, s_byteenable, ad[own_m], wd[own_m], be[own_m]);
      end
    end

    last_acc = acc ? own_m : -1;
    if (s_readdatavalid) begin
      if (tagq.size() > 0) void'(tagq.pop_front());
      else err_m = 1;
    end
    if (acc && e_sr) tagq.push_back(own_m);
    if (own_m < 0) begin
      if (req[0] && (prio_m == 0 || !req[1])) own_m = 0;
      else if (req[1])                         own_m = 1;
    end else begin
      oth = 1 - own_m;
      if (acc) begin
        prio_m = oth;
        if (req[oth]) own_m = oth;
      end else if (!req[own_m]) begin
        own_m = req[oth] ? oth : -1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Assert reset with busy inputs, check the reset-time outputs, release.
  task automatic do_reset();
    m0_read = 1; m1_write = 1; s_readdatavalid = 1;
    reset_n = 0;
    #1;
    checks++; if (s_read !== 0 || s_write !== 0) begin errors++;
      $display("FAIL reset slave cmd: got %b%b exp 00", s_read, s_write); end
    checks++; if (m0_waitrequest !== 1 || m1_waitrequest !== 1) begin errors++;
      $display("FAIL reset waitrequest: got %b%b exp 11", m0_waitrequest, m1_waitrequest); end
    checks++; if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin errors++;
      $display("FAIL reset readdatavalid: got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
    checks++; if (rd_pending !== '0 || err_unexp_rdv !== 0) begin errors++;
      $display("FAIL reset status: got %0d/%b exp 0/0", rd_pending, err_unexp_rdv); end
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
    model_reset();
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 20 && tagq.size() > 0; i++) begin
      s_readdatavalid = 1;
      s_readdata = DATA_W'($urandom);
      tick();
    end
    s_readdatavalid = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    m0_write = 1; m0_address = 25'h0000010; m0_writedata = 16'h1234; m0_byteenable = 2'b11;
    #1;
    checks++; if (s_write !== 0 || m0_waitrequest !== 1) begin errors++;
      $display("FAIL wr idle cycle: got s_write=%b wait=%b exp 0/1", s_write, m0_waitrequest); end
    tick();
    #1;
    checks++;
    if (s_write !== 1 || m0_waitrequest !== 0 || s_address !== 25'h10 || s_writedata !== 16'h1234) begin
      errors++;
      $display("FAIL wr own cycle: got %b/%b/%h/%h exp 1/0/10/1234", s_write, m0_waitrequest,
               s_address, s_writedata);
    end
    tick();
    m0_write = 0;
    #1;
    checks++; if (s_write !== 0) begin errors++;
      $display("FAIL wr single pulse: got s_write=%b exp 0", s_write); end
    tick();
  endtask

  task automatic test_alternating_reads();
    int seq[$];
    int bad;
    do_reset();
    m0_read = 1; m1_read = 1; m0_address = 25'h100; m1_address = 25'h200;
    for (int i = 0; i < 12; i++) begin
      s_readdatavalid = (tagq.size() > 0);
      s_readdata = DATA_W'($urandom);
      tick();
      if (last_acc >= 0) seq.push_back(last_acc);
    end
    checks++; if (seq.size() != 11) begin errors++;
      $display("FAIL alt throughput: got %0d accepts exp 11", seq.size()); end
    bad = 0;
    for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) bad++;
    checks++; if (seq.size() == 0 || seq[0] != 0 || bad != 0) begin errors++;
      $display("FAIL alt order: got first=%0d repeats=%0d exp 0/0",
               (seq.size() > 0) ? seq[0] : -1, bad); end
    drain();
  endtask

  task automatic test_tag_full();
    int n_acc;
    do_reset();
    n_acc = 0;
    m0_read = 1;
    for (int i = 0; i < 8; i++) begin
      m0_address = ADDR_W'(32'h300 + n_acc);
      tick();
      if (last_acc == 0) n_acc++;
    end
    m0_address = ADDR_W'(32'h300 + n_acc);
    #1;
    checks++; if (n_acc != 4 || rd_pending !== CNT_W'(4) || m0_waitrequest !== 1) begin errors++;
      $display("FAIL full stall: got acc=%0d pend=%0d wait=%b exp 4/4/1", n_acc, rd_pending,
               m0_waitrequest); end
    m0_read = 0; m0_write = 1; m0_writedata = 16'hBEEF;
    #1;
    checks++; if (m0_waitrequest !== 0 || s_write !== 1) begin errors++;
      $display("FAIL full write: got wait=%b s_write=%b exp 0/1", m0_waitrequest, s_write); end
    tick();
    m0_write = 0; m0_read = 1;
    #1;
    checks++; if (rd_pending !== CNT_W'(4) || m0_waitrequest !== 1) begin errors++;
      $display("FAIL full after write: got pend=%0d wait=%b exp 4/1", rd_pending, m0_waitrequest); end
    tick();
    s_readdatavalid = 1; s_readdata = 16'hA5A5;
    #1;
    checks++; if (m0_readdatavalid !== 1 || m0_waitrequest !== 1) begin errors++;
      $display("FAIL full pop: got rdv=%b wait=%b exp 1/1", m0_readdatavalid, m0_waitrequest); end
    tick();
    s_readdatavalid = 0;
    #1;
    checks++; if (m0_waitrequest !== 0 || s_read !== 1) begin errors++;
      $display("FAIL fifth read: got wait=%b s_read=%b exp 0/1", m0_waitrequest, s_read); end
    tick();
    drain();
  endtask

  task automatic test_wait_hold();
    do_reset();
    m1_read = 1; m1_address = 25'h01AB;
    tick();
    m0_read = 1; m0_address = 25'h00CD; s_waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (s_address !== 25'h01AB || s_read !== 1 || m1_waitrequest !== 1 || m0_waitrequest !== 1) begin
        errors++;
        $display("FAIL hold c%0d: got %h/%b/%b/%b exp 1ab/1/1/1", i, s_address, s_read,
                 m1_waitrequest, m0_waitrequest);
      end
      tick();
    end
    s_waitrequest = 0;
    #1;
    checks++; if (m1_waitrequest !== 0 || s_address !== 25'h01AB) begin errors++;
      $display("FAIL hold accept: got wait=%b addr=%h exp 0/1ab", m1_waitrequest, s_address); end
    tick();
    m1_read = 0;
    #1;
    checks++; if (s_address !== 25'h00CD || m0_waitrequest !== 0) begin errors++;
      $display("FAIL hold handover: got addr=%h wait=%b exp cd/0", s_address, m0_waitrequest); end
    tick();
    drain();
  endtask

  task automatic test_unexp_rdv();
    do_reset();
    s_readdatavalid = 1;
    #1;
    checks++; if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0 || err_unexp_rdv !== 0) begin
      errors++;
      $display("FAIL unexp same cycle: got %b%b err=%b exp 00/0", m0_readdatavalid,
               m1_readdatavalid, err_unexp_rdv);
    end
    tick();
    s_readdatavalid = 0;
    repeat (5) tick();
    checks++; if (err_unexp_rdv !== 1) begin errors++;
      $display("FAIL unexp sticky: got %b exp 1", err_unexp_rdv); end
    do_reset();
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    m1_read = 1; m1_address = 25'h0777;
    tick();
    tick();
    m1_read = 0;
    #1;
    checks++; if (rd_pending !== CNT_W'(1)) begin errors++;
      $display("FAIL midflight pending: got %0d exp 1", rd_pending); end
    tick();
    do_reset();
    s_readdatavalid = 1;
    #1;
    checks++; if (m1_readdatavalid !== 0) begin errors++;
      $display("FAIL midflight stale rdv: got %b exp 0", m1_readdatavalid); end
    tick();
    s_readdatavalid = 0;
    #1;
    checks++; if (err_unexp_rdv !== 1) begin errors++;
      $display("FAIL midflight err: got %b exp 1", err_unexp_rdv); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      m0_read  = ($urandom % 3) == 0;
      m0_write = ($urandom % 3) == 0;
      m1_read  = ($urandom % 3) == 0;
      m1_write = ($urandom % 3) == 0;
      m0_address = ADDR_W'($urandom); m1_address = ADDR_W'($urandom);
      m0_writedata = DATA_W'($urandom); m1_writedata = DATA_W'($urandom);
      m0_byteenable = BE_W'($urandom); m1_byteenable = BE_W'($urandom);
      s_waitrequest = ($urandom % 4) == 0;
      s_readdatavalid = (tagq.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 25 == 0);
      s_readdata = DATA_W'($urandom);
      tick();
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_alternating_reads();
    test_tag_full();
    test_wait_hold();
    test_unexp_rdv();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
